norm_frame_sched: RTL and testbench

- Frame-level scheduler and controller for the sum-of-squares / square-root datapath.
- Shares one accumulate-and-root engine between two sample requesters using round-robin arbitration at frame granularity.
- Per frame: clears the accumulator, accumulates a*a for each accepted sample, runs a multi-cycle integer square root, then presents root, requester id and sample count on a ready/valid output.
- Sits between the sample producers and the downstream norm consumer.

---
 rtl/norm_sched_pkg.sv | 16 +
 rtl/isqrt_seq.sv | 81 ++++++++
 rtl/norm_frame_sched.sv | 140 ++++++++++++++
 tb/tb_norm_frame_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/norm_sched_pkg.sv
// Shared widths, requester count and controller state encoding for the norm frame scheduler.
package norm_sched_pkg;

   localparam int NUM_REQ    = 2;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_ACC_W  = 20;
   localparam int DEF_CNT_W  = 8;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SQRT,
      OUT
   } state_t;

endpackage

// File: rtl/isqrt_seq.sv
// Sequential restoring integer square root, one root bit per cycle.
// Latency: done pulses ROOT_W cycles after the start cycle; root holds until the next start.
// Backpressure: none; a start while running restarts the computation.
module isqrt_seq #(
   parameter int ACC_W = 20
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ACC_W-1:0]     radicand,
   output logic                 done,
   output logic [ACC_W/2-1:0]   root
);

   localparam int ROOT_W = ACC_W / 2;
   localparam int ITW    = $clog2(ROOT_W);

   logic [ACC_W-1:0]  rad_q;
   logic [ROOT_W-1:0] rem_q;
   logic [ROOT_W-1:0] root_q;
   logic [ITW-1:0]    iter_q;
   logic              run_q;
   logic              done_q;

   logic [ACC_W-1:0]  src_rad;
   logic [ROOT_W-1:0] src_rem;
   logic [ROOT_W-1:0] src_root;
   logic [ROOT_W+1:0] rem_sh;
   logic [ROOT_W+1:0] trial;
   logic              ge;
   logic [ROOT_W-1:0] rem_n;
   logic [ROOT_W-1:0] root_n;
   logic [ACC_W-1:0]  rad_n;

   // The start cycle performs the first iteration straight from the radicand.
   // Between iterations the remainder is bounded by 2*root, so ROOT_W bits suffice.
   always_comb begin
      src_rad  = start ? radicand : rad_q;
      src_rem  = start ? '0 : rem_q;
      src_root = start ? '0 : root_q;
      rem_sh   = {src_rem, src_rad[ACC_W-1:ACC_W-2]};
      trial    = {src_root, 2'b01};
      ge       = (rem_sh >= trial);
      rem_n    = ge ? (rem_sh[ROOT_W-1:0] - trial[ROOT_W-1:0]) : rem_sh[ROOT_W-1:0];
      root_n   = {src_root[ROOT_W-2:0], ge};
      rad_n    = {src_rad[ACC_W-3:0], 2'b00};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         iter_q <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start) begin
            rad_q  <= rad_n;
            rem_q  <= rem_n;
            root_q <= root_n;
            iter_q <= ITW'(ROOT_W - 1);
            run_q  <= 1'b1;
         end else if (run_q) begin
            rad_q  <= rad_n;
            rem_q  <= rem_n;
            root_q <= root_n;
            iter_q <= iter_q - 1'b1;
            if (iter_q == ITW'(1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done = done_q;
   assign root = root_q;

endmodule

// File: rtl/norm_frame_sched.sv
// Round-robin frame scheduler sharing one sum-of-squares / square-root engine between two requesters.
// Latency: result valid ACC_W/2+1 edges after the last sample of a frame is accepted.
// Backpressure: in_ready only for the granted requester in ACCUM; result held until out_ready. NORM_SAT_EN: saturating accumulate + overflow.
module norm_frame_sched
   import norm_sched_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               in_valid,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]   in_data,
   input  logic [NUM_REQ-1:0]               in_last,
   output logic [NUM_REQ-1:0]               in_ready,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [ACC_W/2-1:0]               out_root,
   output logic                             out_id,
   output logic [CNT_W-1:0]                 out_count,
   output logic                             busy
`ifdef NORM_SAT_EN
   ,
   output logic                             overflow
`endif
);

   localparam int ROOT_W = ACC_W / 2;

   state_t             state_q, state_n;
   logic               gnt_q;
   logic               last_q;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               start_q;
   logic               sqrt_done;
   logic [ROOT_W-1:0]  root_w;

   logic               gnt_sel;
   logic               hs;
   logic               take_last;
   logic [2*DATA_W-1:0] sq;
   logic [ACC_W-1:0]   sq_ext;
   logic [ACC_W-1:0]   acc_add;

   // Both valid: serve the one not served last (last_q resets to 1 so requester 0 wins first).
   assign gnt_sel = (&in_valid) ? ~last_q : in_valid[1];
   assign sq      = in_data[gnt_q] * in_data[gnt_q];
   assign sq_ext  = {{(ACC_W-2*DATA_W){1'b0}}, sq};

`ifdef NORM_SAT_EN
   logic               ovf_q;
   logic [ACC_W:0]     sum_wide;
   assign sum_wide = {1'b0, acc_q} + {1'b0, sq_ext};
   assign acc_add  = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
   assign overflow = ovf_q;
`else
   assign acc_add  = acc_q + sq_ext;
`endif

   always_comb begin
      state_n   = state_q;
      in_ready  = '0;
      hs        = 1'b0;
      take_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (|in_valid) state_n = ACCUM;
         end
         ACCUM: begin
            in_ready[gnt_q] = 1'b1;
            hs              = in_valid[gnt_q];
            take_last       = hs && in_last[gnt_q];
            if (take_last) state_n = SQRT;
         end
         SQRT: begin
            if (sqrt_done) state_n = OUT;
         end
         OUT: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_n;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         acc_q   <= '0;
         cnt_q   <= '0;
         start_q <= 1'b0;
`ifdef NORM_SAT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         start_q <= take_last;
         if (state_q == IDLE && |in_valid) begin
            gnt_q <= gnt_sel;
            acc_q <= '0;
            cnt_q <= '0;
`ifdef NORM_SAT_EN
            ovf_q <= 1'b0;
`endif
         end
         if (hs) begin
            acc_q <= acc_add;
            if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
`ifdef NORM_SAT_EN
            if (sum_wide[ACC_W]) ovf_q <= 1'b1;
`endif
         end
         if (state_q == OUT && out_ready) last_q <= gnt_q;
      end
   end

   isqrt_seq #(
      .ACC_W (ACC_W)
   ) u_isqrt (
      .clk      (clk),
      .reset    (reset),
      .start    (start_q),
      .radicand (acc_q),
      .done     (sqrt_done),
      .root     (root_w)
   );

   assign out_valid = (state_q == OUT);
   assign busy      = (state_q != IDLE);
   assign out_id    = gnt_q;
   assign out_count = cnt_q;
   assign out_root  = root_w;

endmodule

// File: tb/tb_norm_frame_sched.sv
// Directed self-checking bench for norm_frame_sched; inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_norm_frame_sched;

   logic            clk;
   logic            reset;
   logic [1:0]      in_valid;
   logic [1:0][7:0] in_data;
   logic [1:0]      in_last;
   logic [1:0]      in_ready;
   logic            out_valid;
   logic            out_ready;
   logic [9:0]      out_root;
   logic            out_id;
   logic [7:0]      out_count;
   logic            busy;
`ifdef NORM_SAT_EN
   logic            overflow;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   norm_frame_sched dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_root  (out_root),
      .out_id    (out_id),
      .out_count (out_count),
      .busy      (busy)
`ifdef NORM_SAT_EN
      ,
      .overflow  (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int id, input int data, input bit last);
      in_valid[id] = 1'b1;
      in_data[id]  = 8'(data);
      in_last[id]  = last;
      for (int i = 0; i < 20 && !in_ready[id]; i++) tick();
      check("in_ready_wait", in_ready[id], 1);
      tick();
      in_valid[id] = 1'b0;
      in_last[id]  = 1'b0;
   endtask

   task automatic wait_result;
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
         tick();
         n++;
         check("in_ready_idle_engine", in_ready, 0);
      end
      check("out_valid_rise", out_valid, 1);
      check("latency_edges", n, 11);
   endtask

   task automatic check_out(input int root, input int id, input int cnt);
      check("out_root", out_root, root);
      check("out_id", out_id, id);
      check("out_count", out_count, cnt);
      check("busy_out", busy, 1);
   endtask

   task automatic accept;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("out_valid_after_accept", out_valid, 0);
      check("busy_after_accept", busy, 0);
   endtask

   initial begin
      reset     = 1'b0;
      in_valid  = '0;
      in_data   = '0;
      in_last   = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_out_root", out_root, 0);
      check("rst_out_id", out_id, 0);
      check("rst_out_count", out_count, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 0);
`ifdef NORM_SAT_EN
      check("rst_overflow", overflow, 0);
`endif
      reset = 1'b1;
      tick();

      // Frame A: req0 21,36 -> 1737 -> 41; out_ready high early must be harmless
      out_ready = 1'b1;
      send(0, 21, 0);
      check("busy_accum", busy, 1);
      send(0, 36, 1);
      wait_result();
      check_out(41, 0, 2);
      accept();

      // Frame B: req1 64,0,40 -> 5696 -> 75, held 5 cycles while req0 waits
      send(1, 64, 0);
      send(1, 0, 0);
      send(1, 40, 1);
      wait_result();
      check_out(75, 1, 3);
      in_valid[0] = 1'b1;
      in_data[0]  = 8'd5;
      in_last[0]  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", out_valid, 1);
         check("hold_root", out_root, 75);
         check("hold_id", out_id, 1);
         check("hold_count", out_count, 3);
         check("hold_in_ready", in_ready, 0);
      end
      accept();
      check("no_grant_on_accept_edge", in_ready, 0);
      tick();
      check("regrant_req0", in_ready, 2'b01);
      tick();
      in_valid[0] = 1'b0;
      in_last[0]  = 1'b0;
      wait_result();
      check_out(5, 0, 1);
      accept();

      // Frame C: both valid right after reset, one sample each
      reset = 1'b0;
      tick();
      reset = 1'b1;
      in_valid   = 2'b11;
      in_data[0] = 8'd3;
      in_data[1] = 8'd4;
      in_last    = 2'b11;
      tick();
      check("tie_grant_req0", in_ready, 2'b01);
      tick();
      in_valid[0] = 1'b0;
      in_last[0]  = 1'b0;
      wait_result();
      check_out(3, 0, 1);
      accept();
      check("req1_waits_idle", in_ready, 0);
      tick();
      check("grant_req1", in_ready, 2'b10);
      tick();
      in_valid[1] = 1'b0;
      in_last[1]  = 1'b0;
      wait_result();
      check_out(4, 1, 1);
      accept();

      // Frame D: 17 x 255 = 1105425 overflows 20 bits
      for (int i = 0; i < 17; i++) send(0, 255, i == 16);
      wait_result();
`ifdef NORM_SAT_EN
      check_out(1023, 0, 17);
      check("overflow_set", overflow, 1);
`else
      check_out(238, 0, 17);
`endif
      accept();

      // Frame E: reset mid-ACCUM discards the partial frame
      send(0, 100, 0);
      send(0, 200, 0);
      reset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 0);
      check("midrst_count", out_count, 0);
      tick();
      reset = 1'b1;
      send(0, 3, 0);
      send(0, 4, 1);
      wait_result();
      check_out(5, 0, 2);
`ifdef NORM_SAT_EN
      check("overflow_cleared", overflow, 0);
`endif
      accept();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
